raw10_frame_scheduler: RTL and testbench

// - Sequences the combinational RAW10 BGGR pattern generator into complete CSI-2 frames.
// - Per frame it emits: FS short packet, N_LINES x (long-packet header request + payload beats), FE short packet.
// - Drives the generator inputs pixel_index, is_even_line and frame_number.
// - Presents one beat per cycle to the downstream CSI-2 packetizer over a valid/ready handshake.

---
 rtl/csi2_pkg.sv | 27 ++
 rtl/blank_timer.sv | 40 ++++
 rtl/raw10_frame_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_raw10_frame_scheduler.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2_pkg.sv
// Shared CSI-2 definitions for the RAW10 test-pattern path.
// - beat_kind_t : kind of beat presented to the CSI-2 packetizer
// - DT_*        : CSI-2 data-type codes carried in packet headers
// - kind_to_dt  : maps a beat kind to the data type of the packet it belongs to
package csi2_pkg;

    typedef enum logic [1:0] {
        KIND_FS,
        KIND_FE,
        KIND_LH,
        KIND_PL
    } beat_kind_t;

    localparam logic [5:0] DT_FS    = 6'h00;
    localparam logic [5:0] DT_FE    = 6'h01;
    localparam logic [5:0] DT_RAW10 = 6'h2B;

    // Line headers and payload beats both belong to the RAW10 long packet.
    function automatic logic [5:0] kind_to_dt(input beat_kind_t kind);
        case (kind)
            KIND_FS: kind_to_dt = DT_FS;
            KIND_FE: kind_to_dt = DT_FE;
            default: kind_to_dt = DT_RAW10;
        endcase
    endfunction

endpackage

// File: rtl/blank_timer.sv
// Loadable down-counter used to time line and frame blanking.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : load load_value into the counter this cycle
//   load_value  : number of cycles to count (0 means never pulse)
//   done        : high during the last counted cycle
module blank_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A load of N makes done fire on the Nth cycle after the load edge.
    assign done = (count_q == WIDTH'(1));

endmodule

// File: rtl/raw10_frame_scheduler.sv
// Sequences the RAW10 BGGR pattern generator into complete CSI-2 frames:
// FS, N_LINES x (line header + payload beats), FE, with line and frame blanking.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset (release synchronised internally)
//   enable        : level, start/continue generating frames
//   out_ready     : downstream accepts the current beat
//   out_valid     : beat valid
//   out_kind      : beat kind (csi2_pkg::beat_kind_t)
//   pixel_index   : byte index within the line, to the generator
//   is_even_line  : 1 on even lines (B/G rows), to the generator
//   frame_number  : current frame, to the generator and FS/FE data field
//   line_number   : current line, 0-based
//   payload_last  : marks the final payload beat of a line
//   busy          : 1 from FS issue until FE accepted and frame blanking done
module raw10_frame_scheduler
    import csi2_pkg::*;
#(
    parameter int unsigned N_MIPI_LANES   = 2,
    parameter int unsigned BUS_WIDTH      = 8,
    parameter int unsigned WIDTH_N_PIXELS = 13,
    parameter int unsigned LINE_BYTES     = 3240,
    parameter int unsigned N_LINES        = 1080,
    parameter int unsigned LINE_BLANK     = 16,
    parameter int unsigned FRAME_BLANK    = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [1:0]                out_kind,
    output logic [WIDTH_N_PIXELS-1:0] pixel_index,
    output logic                      is_even_line,
    output logic [15:0]               frame_number,
    output logic [15:0]               line_number,
    output logic                      payload_last,
    output logic                      busy
);

    if (LINE_BYTES % (5 * N_MIPI_LANES) != 0) begin : gen_bad_line_bytes
        $error("LINE_BYTES must be a multiple of 5*N_MIPI_LANES");
    end
    if (LINE_BYTES >= (2 ** WIDTH_N_PIXELS)) begin : gen_bad_pixel_width
        $error("LINE_BYTES does not fit in WIDTH_N_PIXELS bits");
    end
    if (N_LINES < 2) begin : gen_bad_n_lines
        $error("N_LINES must be at least 2");
    end
    if (BUS_WIDTH != 8) begin : gen_bad_bus_width
        $error("RAW10 packing assumes byte-wide lanes");
    end

    typedef enum logic [2:0] {
        StIdle,
        StFs,
        StLh,
        StPl,
        StLblank,
        StFe,
        StFblank
    } state_t;

    localparam logic [WIDTH_N_PIXELS-1:0] PixStep  = WIDTH_N_PIXELS'(N_MIPI_LANES);
    localparam logic [WIDTH_N_PIXELS-1:0] PixLast  = WIDTH_N_PIXELS'(LINE_BYTES - N_MIPI_LANES);
    localparam logic [15:0]               LineLast = 16'(N_LINES - 1);
    localparam bit LineBlankZero  = (LINE_BLANK == 0);
    localparam bit FrameBlankZero = (FRAME_BLANK == 0);

    // Assertion is asynchronous; release is re-timed to clk.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync_q[1];

    state_t                      state_q, state_d;
    logic [WIDTH_N_PIXELS-1:0]   pixel_q, pixel_d;
    logic                        even_q, even_d;
    logic [15:0]                 frame_q, frame_d;
    logic [15:0]                 line_q, line_d;

    logic        accept;
    logic        last_beat;
    logic        line_more;
    logic        line_done;
    logic        frame_done;
    logic        timer_load;
    logic [15:0] timer_value;
    logic        timer_done;

    assign accept    = out_valid && out_ready;
    assign last_beat = (state_q == StPl) && (pixel_q == PixLast);
    assign line_more = (line_q < LineLast);

    // With zero blanking the blank state is skipped entirely so lines run back to back.
    assign line_done  = ((state_q == StPl) && accept && last_beat && LineBlankZero) ||
                        ((state_q == StLblank) && timer_done);
    assign frame_done = ((state_q == StFe) && accept && FrameBlankZero) ||
                        ((state_q == StFblank) && timer_done);

    assign timer_load  = ((state_q == StPl) && accept && last_beat && !LineBlankZero) ||
                         ((state_q == StFe) && accept && !FrameBlankZero);
    assign timer_value = (state_q == StPl) ? 16'(LINE_BLANK) : 16'(FRAME_BLANK);

    blank_timer #(
        .WIDTH (16)
    ) u_blank_timer (
        .clk        (clk),
        .rst_n      (rst_int_n),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (enable) state_d = StFs;
            StFs:   if (accept) state_d = StLh;
            StLh:   if (accept) state_d = StPl;
            StPl: begin
                if (accept && last_beat) begin
                    if (LineBlankZero) begin
                        state_d = line_more ? StLh : StFe;
                    end else begin
                        state_d = StLblank;
                    end
                end
            end
            StLblank: if (line_done) state_d = line_more ? StLh : StFe;
            StFe: begin
                if (accept) begin
                    if (FrameBlankZero) begin
                        state_d = enable ? StFs : StIdle;
                    end else begin
                        state_d = StFblank;
                    end
                end
            end
            // enable is looked at only on the final blanking cycle.
            StFblank: if (frame_done) state_d = enable ? StFs : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Generator-facing counters only move on accepted beats or blank completion,
    // so they hold steady while a beat is stalled.
    always_comb begin
        pixel_d = pixel_q;
        even_d  = even_q;
        line_d  = line_q;
        frame_d = frame_q;
        case (state_q)
            StFs: begin
                if (accept) begin
                    line_d = '0;
                    even_d = 1'b1;
                end
            end
            StLh: if (accept) pixel_d = '0;
            StPl: if (accept) pixel_d = last_beat ? '0 : pixel_q + PixStep;
            StFe: if (accept) frame_d = frame_q + 16'd1;
            default: ;
        endcase
        if (line_done && line_more) begin
            line_d = line_q + 16'd1;
            even_d = ~even_q;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            pixel_q <= '0;
            even_q  <= 1'b1;
            frame_q <= '0;
            line_q  <= '0;
        end else begin
            pixel_q <= pixel_d;
            even_q  <= even_d;
            frame_q <= frame_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_kind  = KIND_FS;
        unique case (state_q)
            StFs: begin
                out_valid = 1'b1;
                out_kind  = KIND_FS;
            end
            StLh: begin
                out_valid = 1'b1;
                out_kind  = KIND_LH;
            end
            StPl: begin
                out_valid = 1'b1;
                out_kind  = KIND_PL;
            end
            StFe: begin
                out_valid = 1'b1;
                out_kind  = KIND_FE;
            end
            default: ;
        endcase
        busy         = (state_q != StIdle);
        payload_last = last_beat;
    end

    assign pixel_index  = pixel_q;
    assign is_even_line = even_q;
    assign frame_number = frame_q;
    assign line_number  = line_q;

endmodule

// File: tb/tb_raw10_frame_scheduler.sv
module tb_raw10_frame_scheduler;
    import csi2_pkg::*;

    localparam int unsigned NLANE   = 2;
    localparam int unsigned LBYTES  = 20;
    localparam int unsigned NLINES  = 4;
    localparam int unsigned LBLANK  = 2;
    localparam int unsigned FBLANK  = 3;
    localparam int unsigned WP      = 13;
    localparam int unsigned BEATS   = LBYTES / NLANE;
    localparam int unsigned LINECYC = 1 + BEATS + LBLANK;

    typedef struct {
        logic [1:0]    kind;
        logic [15:0]   frame;
        logic [15:0]   line;
        logic          even;
        logic [WP-1:0] pix;
        logic          last;
        int            off;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          out_ready;
    logic          out_valid;
    logic [1:0]    out_kind;
    logic [WP-1:0] pixel_index;
    logic          is_even_line;
    logic [15:0]   frame_number;
    logic [15:0]   line_number;
    logic          payload_last;
    logic          busy;

    logic          en0;
    logic          ready0;
    logic          valid0;
    logic [1:0]    kind0;
    logic [WP-1:0] pix0;
    logic          even0;
    logic [15:0]   frame0;
    logic [15:0]   line0;
    logic          last0;
    logic          busy0;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    fs_cyc = 0;
    bit    rand_ready = 1'b0;
    bit    timing_on = 1'b0;
    beat_t exp_q[$];

    raw10_frame_scheduler #(
        .N_MIPI_LANES   (NLANE),
        .BUS_WIDTH      (8),
        .WIDTH_N_PIXELS (WP),
        .LINE_BYTES     (LBYTES),
        .N_LINES        (NLINES),
        .LINE_BLANK     (LBLANK),
        .FRAME_BLANK    (FBLANK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_kind     (out_kind),
        .pixel_index  (pixel_index),
        .is_even_line (is_even_line),
        .frame_number (frame_number),
        .line_number  (line_number),
        .payload_last (payload_last),
        .busy         (busy)
    );

    raw10_frame_scheduler #(
        .N_MIPI_LANES   (NLANE),
        .BUS_WIDTH      (8),
        .WIDTH_N_PIXELS (WP),
        .LINE_BYTES     (LBYTES),
        .N_LINES        (NLINES),
        .LINE_BLANK     (0),
        .FRAME_BLANK    (0)
    ) dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (en0),
        .out_ready    (ready0),
        .out_valid    (valid0),
        .out_kind     (kind0),
        .pixel_index  (pix0),
        .is_even_line (even0),
        .frame_number (frame0),
        .line_number  (line0),
        .payload_last (last0),
        .busy         (busy0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected beats of one frame, derived from the frame layout rules.
    task automatic push_frame(input logic [15:0] f);
        beat_t b;
        b = '{kind: KIND_FS, frame: f, line: 0, even: 1'b1, pix: '0, last: 1'b0, off: 0};
        exp_q.push_back(b);
        for (int l = 0; l < NLINES; l++) begin
            b = '{kind: KIND_LH, frame: f, line: 16'(l), even: (l % 2 == 0), pix: '0,
                  last: 1'b0, off: 1 + l * LINECYC};
            exp_q.push_back(b);
            for (int k = 0; k < BEATS; k++) begin
                b = '{kind: KIND_PL, frame: f, line: 16'(l), even: (l % 2 == 0),
                      pix: WP'(k * NLANE), last: (k == BEATS - 1), off: 2 + l * LINECYC + k};
                exp_q.push_back(b);
            end
        end
        b = '{kind: KIND_FE, frame: f, line: 16'(NLINES - 1), even: ((NLINES - 1) % 2 == 0),
              pix: '0, last: 1'b0, off: 1 + NLINES * LINECYC};
        exp_q.push_back(b);
    endtask

    task automatic wait_q_le(input int n, input int budget, input string name);
        int i;
        i = 0;
        while (exp_q.size() > n && i < budget) begin
            @(posedge clk);
            i++;
        end
        if (exp_q.size() > n) begin
            failures++;
            $display("FAIL %s timeout actual=%0d beats pending required<=%0d", name,
                     exp_q.size(), n);
        end
        #1;
    endtask

    task automatic blank_len(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_kind"}, out_kind, KIND_FS);
        check({tag, "_pix"}, pixel_index, 0);
        check({tag, "_even"}, is_even_line, 1);
        check({tag, "_frame"}, frame_number, 0);
        check({tag, "_line"}, line_number, 0);
        check({tag, "_last"}, payload_last, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Compare process: every valid beat against the model, every stall for stability.
    logic [50:0] snap;
    bit          stalled = 1'b0;
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_stable", {out_valid, out_kind, pixel_index, is_even_line,
                      frame_number, line_number, payload_last, busy}, snap);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", out_kind, 2'bxx);
                end else begin
                    e = exp_q[0];
                    check("kind", out_kind, e.kind);
                    check("frame", frame_number, e.frame);
                    check("payload_last", payload_last, e.last);
                    if (e.kind != KIND_FS) begin
                        check("line", line_number, e.line);
                        check("even", is_even_line, e.even);
                    end
                    if (e.kind == KIND_PL) check("pixel", pixel_index, e.pix);
                    if (out_ready) begin
                        if (e.kind == KIND_FS) fs_cyc = cyc;
                        if (timing_on) check("beat_offset", cyc - fs_cyc, e.off);
                        void'(exp_q.pop_front());
                    end
                end
            end
            stalled = out_valid && !out_ready;
            snap = {out_valid, out_kind, pixel_index, is_even_line, frame_number,
                    line_number, payload_last, busy};
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int gap;
        logic [1:0] first_kind;
        logic [1:0] last_kind;

        rst_n = 1'b0;
        enable = 1'b0;
        out_ready = 1'b0;
        en0 = 1'b0;
        ready0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_valid", out_valid, 0);
        check("idle_busy", busy, 0);

        // Two back-to-back frames at full throughput, exact beat timing.
        push_frame(16'd0);
        check("model_len", exp_q.size(), 46);
        check("model_last_pix", exp_q[11].pix, 18);
        check("model_last_flag", exp_q[11].last, 1);
        check("model_lh1_even", exp_q[12].even, 0);
        check("model_fe_kind", exp_q[45].kind, KIND_FE);
        check("model_fe_off", exp_q[45].off, 53);
        push_frame(16'd1);
        out_ready = 1'b1;
        timing_on = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        check("fs_not_yet", out_valid, 0);
        @(negedge clk);
        check("fs_latency_valid", out_valid, 1);
        check("fs_latency_kind", out_kind, KIND_FS);
        check("fs_busy", busy, 1);
        wait_q_le(45, 400, "frame0");
        enable = 1'b0;
        wait_q_le(0, 400, "frame1");
        blank_len(n);
        check("fblank_len_a", n, FBLANK);
        check("idle_after_a", busy, 0);

        // Random backpressure; enable dropped right after the first line header.
        timing_on = 1'b0;
        rand_ready = 1'b1;
        push_frame(16'd2);
        enable = 1'b1;
        wait_q_le(44, 800, "frame2_lh");
        enable = 1'b0;
        wait_q_le(0, 1500, "frame2");
        blank_len(n);
        check("fblank_len_b", n, FBLANK);
        check("idle_after_b", busy, 0);
        check("idle_valid_b", out_valid, 0);

        // Frame counter wrap.
        rand_ready = 1'b0;
        out_ready = 1'b1;
        timing_on = 1'b1;
        force dut.frame_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.frame_q;
        @(negedge clk);
        check("forced_frame", frame_number, 16'hFFFF);
        push_frame(16'hFFFF);
        push_frame(16'h0000);
        @(posedge clk);
        #1;
        enable = 1'b1;
        wait_q_le(45, 400, "frame_ffff");
        enable = 1'b0;
        wait_q_le(0, 400, "frame_wrap");
        blank_len(n);
        check("frame_after_wrap", frame_number, 1);

        // Reset in the middle of line 2 payload.
        timing_on = 1'b0;
        rand_ready = 1'b1;
        push_frame(16'd1);
        enable = 1'b1;
        n = 0;
        while (!(out_valid && out_kind == KIND_PL && line_number == 16'd2) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reached_line2_pl", n < 1000, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        push_frame(16'd0);
        rst_n = 1'b1;
        wait_q_le(45, 800, "post_reset_fs");
        enable = 1'b0;
        wait_q_le(0, 1500, "post_reset_frame");
        blank_len(n);
        check("idle_after_c", busy, 0);

        // Zero-blanking instance: one frame, no gaps between valid beats.
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        en0 = 1'b1;
        n = 0;
        gap = 0;
        first_kind = 2'b11;
        last_kind = 2'b11;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (valid0) begin
                if (n == 0) first_kind = kind0;
                en0 = 1'b0;
                n++;
                last_kind = kind0;
                if (kind0 == KIND_FE) break;
            end else if (n > 0) begin
                gap++;
            end
        end
        check("zb_first_kind", first_kind, KIND_FS);
        check("zb_last_kind", last_kind, KIND_FE);
        check("zb_valid_beats", n, 1 + NLINES * (1 + BEATS) + 1);
        check("zb_gaps", gap, 0);
        check("zb_frame", frame0, 0);
        @(negedge clk);
        check("zb_idle", busy0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
